// File: rtl/vga_rx_monitor.sv
// VGA sink monitor: registers the pixel stream, recovers x/y coordinates, checks
// line/frame timing, locks onto a clean stream and signs every locked frame.
module vga_rx_monitor #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int H_TOTAL  = 800,
   parameter int V_TOTAL  = 525,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        de,
   input  logic [5:0]  rgb,
   input  logic        err_clr,
   output logic        pix_valid,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [5:0]  pix_rgb,
   output logic        locked,
   output logic        frame_done,
   output logic [15:0] frame_sig,
   output logic [2:0]  err,
   output logic [1:0]  state_dbg
);

   localparam logic [10:0] H_TOTAL_C  = 11'(H_TOTAL);
   localparam logic [10:0] H_ACTIVE_C = 11'(H_ACTIVE);
   localparam logic [10:0] V_TOTAL_C  = 11'(V_TOTAL);
   localparam logic [9:0]  V_ACTIVE_C = 10'(V_ACTIVE);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic        prev_ok, hs_prev, vs_prev;
   logic        hs_act, vs_act, hs_edge, vs_edge, de_rise, de_fall;
   logic [10:0] h_cnt, d_cnt, hs_total;
   logic [9:0]  line_cnt;
   logic [15:0] sig;
   logic        skip_line, frame_bad;
   logic [1:0]  good_cnt, good_nxt;
   logic        line_chk, htotal_bad, hactive_bad, line_bad, vtotal_bad;
   logic        frame_ok, frame_fire, enter_measure;

   // hs_prev/vs_prev hold the active-level flag of the previous sample;
   // prev_ok masks the first sample after reset so it never forms an edge.
   assign hs_act  = (hsync == SYNC_POL);
   assign vs_act  = (vsync == SYNC_POL);
   assign hs_edge = prev_ok && hs_act && !hs_prev;
   assign vs_edge = prev_ok && vs_act && !vs_prev;
   assign de_rise = de && !pix_valid;
   assign de_fall = !de && pix_valid;

   // A sync edge coinciding with vsync still belongs to the closing frame.
   assign hs_total    = {1'b0, line_cnt} + {10'b0, hs_edge};
   assign line_chk    = hs_edge && !skip_line && (state != SEARCH);
   assign htotal_bad  = line_chk && (h_cnt != H_TOTAL_C);
   assign hactive_bad = line_chk && (d_cnt != 11'd0) && (d_cnt != H_ACTIVE_C);
   assign line_bad    = htotal_bad || hactive_bad;
   assign vtotal_bad  = vs_edge && (state != SEARCH) &&
                        ((hs_total != V_TOTAL_C) || (pix_y != V_ACTIVE_C));
   assign state_dbg   = state;

   always_comb begin
      state_nxt     = state;
      good_nxt      = good_cnt;
      enter_measure = 1'b0;
      frame_ok      = !frame_bad && !line_bad && !vtotal_bad;
      case (state)
         SEARCH: begin
            if (vs_edge) begin
               state_nxt     = MEASURE;
               enter_measure = 1'b1;
               good_nxt      = 2'd0;
            end
         end
         MEASURE: begin
            if (vs_edge) begin
               good_nxt = frame_ok ? good_cnt + 2'd1 : 2'd0;
               if (good_nxt == 2'd2) state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            if (line_bad || vtotal_bad) begin
               state_nxt = SEARCH;
               good_nxt  = 2'd0;
            end
         end
         default: state_nxt = SEARCH;
      endcase
      frame_fire = vs_edge && ((state == LOCKED) ||
                               ((state == MEASURE) && (state_nxt == LOCKED)));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= SEARCH;
         good_cnt <= 2'd0;
         locked   <= 1'b0;
      end else begin
         state    <= state_nxt;
         good_cnt <= good_nxt;
         locked   <= (state_nxt == LOCKED);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_ok    <= 1'b0;
         hs_prev    <= 1'b0;
         vs_prev    <= 1'b0;
         pix_valid  <= 1'b0;
         pix_x      <= 10'd0;
         pix_y      <= 10'd0;
         pix_rgb    <= 6'd0;
         sig        <= 16'd0;
         frame_sig  <= 16'd0;
         frame_done <= 1'b0;
         err        <= 3'd0;
         h_cnt      <= 11'd0;
         d_cnt      <= 11'd0;
         line_cnt   <= 10'd0;
         skip_line  <= 1'b0;
         frame_bad  <= 1'b0;
      end else begin
         prev_ok   <= 1'b1;
         hs_prev   <= hs_act;
         vs_prev   <= vs_act;
         pix_valid <= de;
         pix_rgb   <= rgb;

         if (de) begin
            if (de_rise)                pix_x <= 10'd0;
            else if (pix_x != 10'h3FF)  pix_x <= pix_x + 10'd1;
         end
         if (vs_edge)                           pix_y <= 10'd0;
         else if (de_fall && pix_y != 10'h3FF)  pix_y <= pix_y + 10'd1;

         // Signature is sampled into frame_sig before the clear on the same edge.
         if (vs_edge)  sig <= 16'd0;
         else if (de)  sig <= {sig[14:0], sig[15]} + {10'b0, rgb};
         frame_done <= frame_fire;
         if (frame_fire) frame_sig <= sig;

         err <= (err & ~{3{err_clr}}) | {vtotal_bad, htotal_bad, hactive_bad};

         if (hs_edge)                  h_cnt <= 11'd1;
         else if (h_cnt != 11'h7FF)    h_cnt <= h_cnt + 11'd1;
         if (hs_edge)                  d_cnt <= {10'b0, de};
         else if (de && d_cnt != 11'h7FF) d_cnt <= d_cnt + 11'd1;
         if (vs_edge)                  line_cnt <= 10'd0;
         else if (hs_edge && line_cnt != 10'h3FF) line_cnt <= line_cnt + 10'd1;

         if (vs_edge)       frame_bad <= 1'b0;
         else if (line_bad) frame_bad <= 1'b1;
         if (hs_edge) skip_line <= 1'b0;

         // Fresh measurement window: the line in progress is partial, so skip it.
         if (enter_measure) begin
            h_cnt     <= 11'd0;
            d_cnt     <= 11'd0;
            skip_line <= 1'b1;
            frame_bad <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor using a reduced 8x4 active / 12x6 total raster.
module tb_vga_rx_monitor;

   localparam int HA = 8;
   localparam int VA = 4;
   localparam int HT = 12;
   localparam int VT = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hsync = 1'b1;
   logic        vsync = 1'b1;
   logic        de = 1'b0;
   logic [5:0]  rgb = 6'd0;
   logic        err_clr = 1'b0;
   logic        pix_valid, locked, frame_done;
   logic [9:0]  pix_x, pix_y;
   logic [5:0]  pix_rgb;
   logic [15:0] frame_sig;
   logic [2:0]  err;
   logic [1:0]  state_dbg;

   vga_rx_monitor #(
      .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT), .SYNC_POL(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
      .err_clr(err_clr), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
      .pix_rgb(pix_rgb), .locked(locked), .frame_done(frame_done),
      .frame_sig(frame_sig), .err(err), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int done_cnt = 0;

   always @(negedge clk) if (frame_done) done_cnt++;

   // per-frame hooks, -1 disables
   int         short_line = -1;
   int         hact_line = -1;
   int         clr_line = -1, clr_col = 0;
   int         rst_line = -1, rst_col = 0;
   int         hk_line = -1, hk_col = 0;
   logic [2:0] hk_err = 3'd0;
   logic       hk_lock = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, " pix_valid"}, pix_valid, 0);
      check({tag, " pix_x"}, pix_x, 0);
      check({tag, " pix_y"}, pix_y, 0);
      check({tag, " pix_rgb"}, pix_rgb, 0);
      check({tag, " locked"}, locked, 0);
      check({tag, " frame_done"}, frame_done, 0);
      check({tag, " frame_sig"}, frame_sig, 0);
      check({tag, " err"}, err, 0);
      check({tag, " state"}, state_dbg, 0);
   endtask

   // pat: 0 black, 1 only pixel (0,0)=3F, 2 random pixels
   task automatic send_frame(input int pat, input bit scan, input bit exp_done, input bit exp_lock);
      logic [15:0] esig;
      int len, dl;
      esig = 16'd0;
      for (int ln = 0; ln < VT; ln++) begin
         len = (ln == short_line) ? HT - 1 : HT;
         dl  = (ln == hact_line) ? HA - 1 : HA;
         for (int c = 0; c < len; c++) begin
            de    = (ln < VA) && (c < dl);
            hsync = !((c == HA + 1) || (c == HA + 2));
            vsync = !(ln == VA + 1);
            case (pat)
               0:       rgb = 6'd0;
               1:       rgb = (ln == 0 && c == 0) ? 6'h3F : 6'd0;
               default: rgb = de ? 6'($urandom_range(0, 63)) : 6'd0;
            endcase
            if (de) esig = {esig[14:0], esig[15]} + {10'b0, rgb};
            err_clr = (ln == clr_line) && (c == clr_col);
            rst_n   = !((ln == rst_line) && (c == rst_col));
            step();
            if (!rst_n) begin
               check_zero("midreset");
               rst_n = 1'b1;
            end
            if (scan) begin
               check("scan pix_valid", pix_valid, de);
               if (de) begin
                  check("scan pix_x", pix_x, c);
                  check("scan pix_y", pix_y, ln);
                  check("scan pix_rgb", pix_rgb, rgb);
               end
            end
            if (ln == hk_line && c == hk_col) begin
               check("hook err", err, hk_err);
               check("hook locked", locked, hk_lock);
            end
            if (ln == VA + 1 && c == 0) begin
               check("vs frame_done", frame_done, exp_done);
               check("vs locked", locked, exp_lock);
               if (exp_done) check("vs frame_sig", frame_sig, esig);
            end
         end
      end
      err_clr = 1'b0;
   endtask

   task automatic clear_hooks();
      short_line = -1; hact_line = -1; clr_line = -1; rst_line = -1; hk_line = -1;
   endtask

   initial begin
      int d0;
      rst_n = 1'b0;
      repeat (3) step();
      check_zero("reset");
      rst_n = 1'b1;
      step();
      step();

      // lock on the third vsync edge
      send_frame(0, 0, 0, 0);
      check("after f1 state", state_dbg, 1);
      send_frame(0, 0, 0, 0);
      send_frame(0, 0, 1, 1);
      check("black sig", frame_sig, 16'h0000);
      check("lock err", err, 3'b000);
      check("first done count", done_cnt, 1);
      send_frame(1, 0, 1, 1);
      check("single pixel sig", frame_sig, 16'h801F);
      send_frame(2, 1, 1, 1);

      // short line while locked
      short_line = 2; hk_line = 3; hk_col = 9; hk_err = 3'b010; hk_lock = 1'b0;
      send_frame(0, 0, 0, 0);
      clear_hooks();
      send_frame(2, 0, 0, 0);
      send_frame(2, 0, 1, 1);
      check("sticky htotal", err, 3'b010);

      // hactive error coinciding with err_clr
      hact_line = 1; clr_line = 1; clr_col = 9;
      hk_line = 1; hk_col = 9; hk_err = 3'b001; hk_lock = 1'b0;
      send_frame(0, 0, 0, 0);
      clear_hooks();
      check("set beats clear", err, 3'b001);

      // err_clr alone
      clr_line = 0; clr_col = 0; hk_line = 0; hk_col = 0; hk_err = 3'b000; hk_lock = 1'b0;
      send_frame(2, 0, 0, 0);
      clear_hooks();
      send_frame(2, 0, 1, 1);
      check("err after clear", err, 3'b000);

      // mid-line reset while locked
      d0 = done_cnt;
      rst_line = 2; rst_col = 3;
      send_frame(2, 0, 0, 0);
      clear_hooks();
      send_frame(2, 0, 0, 0);
      check("no done before relock", done_cnt, d0);
      send_frame(2, 0, 1, 1);
      step();
      check("one done at relock", done_cnt, d0 + 1);

      // coordinate saturation
      hsync = 1'b1; vsync = 1'b1; rgb = 6'd0;
      de = 1'b1;
      repeat (1030) step();
      check("pix_x saturate", pix_x, 10'd1023);
      for (int i = 0; i < 1030; i++) begin
         de = 1'b0; step();
         de = 1'b1; step();
      end
      de = 1'b0; step();
      check("pix_y saturate", pix_y, 10'd1023);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
